// File: rtl/regfile_pkg.sv
// Shared constants and the register-id width helper for the scoreboarded register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRP_DEF   = 2;

   // Width of a register id; a single-register file still needs one id bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load tracking: pending bits, write/load accept logic, pending count and
// the error pulse for a load return that nothing was waiting for.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NRP      = NRP_DEF,
   parameter bit ZERO_REG = 1'b1,
   localparam int IDW     = id_width(NREGS)
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [NRP-1:0][IDW-1:0]  i_rp_id,
   input  logic                     i_wr_en,
   input  logic [IDW-1:0]           i_wr_id,
   input  logic                     i_ld_issue,
   input  logic [IDW-1:0]           i_ld_id,
   input  logic                     i_ld_done,
   input  logic [IDW-1:0]           i_ld_done_id,
   output logic [NRP-1:0]           o_rp_busy,
   output logic                     o_wr_ready,
   output logic                     o_ld_ready,
   output logic                     o_wr_acc,
   output logic                     o_done_acc,
   output logic [IDW:0]             o_pend_cnt,
   output logic                     o_err
);

   logic [NREGS-1:0] r_pending;
   logic [IDW:0]     r_pend_cnt;
   logic             r_err;

   logic             w_done_acc;
   logic             w_done_zero;
   logic             w_wr_blk;
   logic             w_ld_blk;
   logic             w_wr_acc;
   logic             w_ld_set;
   logic [NREGS-1:0] w_clr_mask;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_pend_nxt;

   // A same-cycle load return frees its id, so a write or new load to it may proceed.
   always_comb begin
      w_done_zero = ZERO_REG && (i_ld_done_id == {IDW{1'b0}});
      w_done_acc  = i_ld_done && !Rst && r_pending[i_ld_done_id];
      w_wr_blk    = r_pending[i_wr_id] && !(w_done_acc && (i_ld_done_id == i_wr_id));
      w_ld_blk    = r_pending[i_ld_id] && !(w_done_acc && (i_ld_done_id == i_ld_id));
      o_wr_ready  = !Rst && !(i_wr_en && w_wr_blk);
      o_ld_ready  = !Rst && !w_ld_blk;
      w_wr_acc    = i_wr_en && o_wr_ready && !(ZERO_REG && (i_wr_id == {IDW{1'b0}}));
      w_ld_set    = i_ld_issue && o_ld_ready && !(ZERO_REG && (i_ld_id == {IDW{1'b0}}));
      w_clr_mask  = w_done_acc ? ({{(NREGS-1){1'b0}}, 1'b1} << i_ld_done_id) : {NREGS{1'b0}};
      w_set_mask  = w_ld_set   ? ({{(NREGS-1){1'b0}}, 1'b1} << i_ld_id)      : {NREGS{1'b0}};
      // Clear-then-set: a return and a reissue to the same id leave it pending.
      w_pend_nxt  = (r_pending & ~w_clr_mask) | w_set_mask;
      for (int p = 0; p < NRP; p++) begin
         o_rp_busy[p] = r_pending[i_rp_id[p]] && !(w_done_acc && (i_ld_done_id == i_rp_id[p]));
      end
      o_wr_acc    = w_wr_acc;
      o_done_acc  = w_done_acc;
      o_pend_cnt  = r_pend_cnt;
      o_err       = r_err;
   end

   // Pending state, running count and error pulse.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_pending  <= {NREGS{1'b0}};
         r_pend_cnt <= {(IDW+1){1'b0}};
         r_err      <= 1'b0;
      end else begin
         r_pending  <= w_pend_nxt;
         r_pend_cnt <= r_pend_cnt + (IDW+1)'(w_ld_set) - (IDW+1)'(w_done_acc);
         r_err      <= i_ld_done && !r_pending[i_ld_done_id] && !w_done_zero;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with load scoreboard: data array, two write ports (ALU and load
// return) and per-port combinational read bypass.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRP      = NRP_DEF,
   parameter bit ZERO_REG = 1'b1,
   localparam int IDW     = id_width(NREGS)
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [NRP-1:0][IDW-1:0]  Rp_id,
   output logic [NRP-1:0][XLEN-1:0] Rp_data,
   output logic [NRP-1:0]           Rp_busy,
   input  logic                     Wr_en,
   input  logic [IDW-1:0]           Wr_id,
   input  logic [XLEN-1:0]          Wr_data,
   output logic                     Wr_ready,
   input  logic                     Ld_issue,
   input  logic [IDW-1:0]           Ld_id,
   output logic                     Ld_ready,
   input  logic                     Ld_done,
   input  logic [IDW-1:0]           Ld_done_id,
   input  logic [XLEN-1:0]          Ld_data,
   output logic [IDW:0]             Pend_cnt,
   output logic                     Err
);

   logic [XLEN-1:0] r_regs [NREGS];
   logic            w_wr_acc;
   logic            w_done_acc;

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NRP      (NRP),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .Clk          (Clk),
      .Rst          (Rst),
      .i_rp_id      (Rp_id),
      .i_wr_en      (Wr_en),
      .i_wr_id      (Wr_id),
      .i_ld_issue   (Ld_issue),
      .i_ld_id      (Ld_id),
      .i_ld_done    (Ld_done),
      .i_ld_done_id (Ld_done_id),
      .o_rp_busy    (Rp_busy),
      .o_wr_ready   (Wr_ready),
      .o_ld_ready   (Ld_ready),
      .o_wr_acc     (w_wr_acc),
      .o_done_acc   (w_done_acc),
      .o_pend_cnt   (Pend_cnt),
      .o_err        (Err)
   );

   // Load data lands first; an ALU write to the same id is younger and overrides it.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= {XLEN{1'b0}};
         end
      end else begin
         if (w_done_acc) begin
            r_regs[Ld_done_id] <= Ld_data;
         end
         if (w_wr_acc) begin
            r_regs[Wr_id] <= Wr_data;
         end
      end
   end

   // Read bypass: accepted ALU write, then accepted load return, then stored value.
   always_comb begin
      for (int p = 0; p < NRP; p++) begin
         if (ZERO_REG && (Rp_id[p] == {IDW{1'b0}})) begin
            Rp_data[p] = {XLEN{1'b0}};
         end else if (w_wr_acc && (Wr_id == Rp_id[p])) begin
            Rp_data[p] = Wr_data;
         end else if (w_done_acc && (Ld_done_id == Rp_id[p])) begin
            Rp_data[p] = Ld_data;
         end else begin
            Rp_data[p] = r_regs[Rp_id[p]];
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a driver computes expected outputs from an
// architectural model and queues them; a monitor compares mid-cycle.
module tb_regfile_sb;

   localparam int NRP = 2;

   typedef struct {
      bit               chk_rp;
      bit               chk_reg;
      bit               chk_wr;
      bit               chk_ld;
      logic [1:0][31:0] rp_data;
      logic [1:0]       rp_busy;
      logic             wr_ready;
      logic             ld_ready;
      logic [5:0]       pend_cnt;
      logic             err;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [1:0][4:0]  rp_id;
   logic [1:0][31:0] rp_data;
   logic [1:0]       rp_busy;
   logic             wr_en;
   logic [4:0]       wr_id;
   logic [31:0]      wr_data;
   logic             wr_ready;
   logic             ld_issue;
   logic [4:0]       ld_id;
   logic             ld_ready;
   logic             ld_done;
   logic [4:0]       ld_done_id;
   logic [31:0]      ld_data;
   logic [5:0]       pend_cnt;
   logic             err;

   exp_t        exp_q[$];
   logic [31:0] m_mem [32];
   bit          m_pend [32];
   bit          m_err;
   bit          m_known;
   int          n_checks;
   int          n_pass;

   regfile_sb dut (
      .Clk        (clk),
      .Rst        (rst),
      .Rp_id      (rp_id),
      .Rp_data    (rp_data),
      .Rp_busy    (rp_busy),
      .Wr_en      (wr_en),
      .Wr_id      (wr_id),
      .Wr_data    (wr_data),
      .Wr_ready   (wr_ready),
      .Ld_issue   (ld_issue),
      .Ld_id      (ld_id),
      .Ld_ready   (ld_ready),
      .Ld_done    (ld_done),
      .Ld_done_id (ld_done_id),
      .Ld_data    (ld_data),
      .Pend_cnt   (pend_cnt),
      .Err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Expected outputs for the inputs now applied, then the architectural update at the edge.
   task automatic step();
      exp_t e;
      int   cnt;
      bit   dok, wrdy, lrdy, wacc;
      logic [4:0] id;
      cnt = 0;
      for (int i = 0; i < 32; i++) cnt += m_pend[i] ? 1 : 0;
      e.chk_reg  = m_known;
      e.pend_cnt = 6'(cnt);
      e.err      = m_err;
      e.rp_data  = '0;
      e.rp_busy  = '0;
      dok  = !rst && ld_done && m_pend[ld_done_id];
      wrdy = !rst && !(m_pend[wr_id] && !(dok && ld_done_id == wr_id));
      lrdy = !rst && !(m_pend[ld_id] && !(dok && ld_done_id == ld_id));
      wacc = wr_en && wrdy;
      e.wr_ready = wrdy;
      e.ld_ready = lrdy;
      e.chk_wr   = rst || wr_en;
      e.chk_ld   = rst || ld_issue;
      e.chk_rp   = !rst && m_known;
      for (int p = 0; p < NRP; p++) begin
         id = rp_id[p];
         if (id == 5'd0) begin
            e.rp_data[p] = 32'd0;
            e.rp_busy[p] = 1'b0;
         end else begin
            e.rp_data[p] = (wacc && wr_id == id) ? wr_data :
                           (dok && ld_done_id == id) ? ld_data : m_mem[id];
            e.rp_busy[p] = m_pend[id] && !(dok && ld_done_id == id);
         end
      end
      exp_q.push_back(e);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_pend[i] = 1'b0;
         end
         m_err   = 1'b0;
         m_known = 1'b1;
      end else begin
         m_err = ld_done && (ld_done_id != 5'd0) && !m_pend[ld_done_id];
         if (dok) begin
            m_mem[ld_done_id]  = ld_data;
            m_pend[ld_done_id] = 1'b0;
         end
         if (wacc && wr_id != 5'd0) m_mem[wr_id] = wr_data;
         if (ld_issue && lrdy && ld_id != 5'd0) m_pend[ld_id] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic we, input logic [4:0] wid, input logic [31:0] wd,
                      input logic li, input logic [4:0] lid, input logic ld, input logic [4:0] did,
                      input logic [31:0] dd, input logic [4:0] rp1, input logic [4:0] rp0);
      rst = r; wr_en = we; wr_id = wid; wr_data = wd;
      ld_issue = li; ld_id = lid; ld_done = ld; ld_done_id = did; ld_data = dd;
      rp_id[1] = rp1; rp_id[0] = rp0;
      step();
   endtask

   function automatic logic [4:0] pick_id();
      return ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
   endfunction

   task automatic rand_step();
      logic [4:0] pq[$];
      for (int i = 0; i < 32; i++) if (m_pend[i]) pq.push_back(5'(i));
      rst      = ($urandom_range(63) == 0);
      wr_en    = 1'($urandom_range(1));
      wr_id    = pick_id();
      wr_data  = $urandom();
      ld_issue = 1'($urandom_range(1));
      ld_id    = pick_id();
      ld_done  = 1'($urandom_range(1));
      if (pq.size() > 0 && $urandom_range(3) != 0)
         ld_done_id = pq[$urandom_range(pq.size() - 1)];
      else
         ld_done_id = pick_id();
      ld_data  = $urandom();
      rp_id[0] = ($urandom_range(2) == 0) ? ld_done_id : pick_id();
      rp_id[1] = ($urandom_range(2) == 0) ? wr_id : pick_id();
      step();
   endtask

   // Monitor: one queued expectation per cycle, compared at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_reg) begin
               chk("pend_cnt", 32'(pend_cnt), 32'(e.pend_cnt));
               chk("err", 32'(err), 32'(e.err));
            end
            if (e.chk_wr) chk("wr_ready", 32'(wr_ready), 32'(e.wr_ready));
            if (e.chk_ld) chk("ld_ready", 32'(ld_ready), 32'(e.ld_ready));
            if (e.chk_rp) begin
               for (int p = 0; p < NRP; p++) begin
                  chk($sformatf("rp_data[%0d] id %0d", p, rp_id[p]), rp_data[p], e.rp_data[p]);
                  chk($sformatf("rp_busy[%0d] id %0d", p, rp_id[p]), 32'(rp_busy[p]), 32'(e.rp_busy[p]));
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_known  = 1'b0;
      m_err    = 1'b0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      rst = 1'b1; wr_en = 1'b0; wr_id = 5'd0; wr_data = 32'd0;
      ld_issue = 1'b0; ld_id = 5'd0; ld_done = 1'b0; ld_done_id = 5'd0; ld_data = 32'd0;
      rp_id = '0;
      @(posedge clk);
      #1;
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Reset state on reads
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
      // Outstanding load blocks a write, then returns with same-cycle bypass
      drv(0, 0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
      drv(0, 1, 7, 32'h1234_5678, 0, 0, 0, 0, 0, 7, 0);
      drv(0, 0, 0, 0, 0, 0, 1, 7, 32'hDEAD_BEEF, 7, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      // Return to a non-pending id
      drv(0, 0, 0, 0, 0, 0, 1, 3, 32'h5555_5555, 3, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      // Return, reissue and an unrelated write in one cycle
      drv(0, 0, 0, 0, 1, 4, 0, 0, 0, 4, 9);
      drv(0, 1, 9, 32'h22, 1, 4, 1, 4, 32'h11, 4, 9);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 9);
      drv(0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 4, 9);
      // Register zero
      drv(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 1, 0, 32'h99, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Write and return to the same id: write wins
      drv(0, 0, 0, 0, 1, 6, 0, 0, 0, 6, 0);
      drv(0, 1, 6, 32'hBBBB, 0, 0, 1, 6, 32'hAAAA, 6, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
      // Reset in the middle of a load
      drv(0, 0, 0, 0, 1, 2, 0, 0, 0, 2, 0);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
      drv(0, 0, 0, 0, 0, 0, 1, 2, 32'h77, 2, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
      for (int n = 0; n < 3000; n++) rand_step();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, 32, data word width.
REQ-002 Parameter NREGS, 32, register count (power of two, 2..64); IDW = clog2(NREGS).
REQ-003 Parameter NRP, 2, read port count (1..4).
REQ-004 Parameter ZERO_REG, 1, register 0 reads as zero and is never written or marked pending.
REQ-005 Reset Rst, synchronous, active-high; clock Clk.
REQ-006 Clk  in  1  clock; all state updates on rising edge.
REQ-007 Rst  in  1  synchronous active-high reset.
REQ-008 Rp_id  in  NRP x IDW  read port register ids.
REQ-009 Rp_data  out  NRP x XLEN  read data, combinational.
REQ-010 Rp_busy  out  NRP  register has an outstanding load (after same-cycle bypass).
REQ-011 Wr_en / Wr_id / Wr_data  in  1 / IDW / XLEN  ALU writeback port.
REQ-012 Wr_ready  out  1  ALU write accepted this cycle.
REQ-013 Ld_issue / Ld_id  in  1 / IDW  load issued to bus; mark destination pending.
REQ-014 Ld_ready  out  1  load issue accepted this cycle.
REQ-015 Ld_done / Ld_done_id / Ld_data  in  1 / IDW / XLEN  load data return.
REQ-016 Pend_cnt  out  IDW+1  number of pending registers.
REQ-017 Err  out  1  one-cycle pulse: Ld_done to a non-pending id.

Function
REQ-018 Storage: NREGS x XLEN registers plus NREGS pending bits.
REQ-019 Wr_ready = !(Wr_en target pending and not cleared by same-cycle Ld_done); write happens only when Wr_en & Wr_ready.
REQ-020 Ld_ready = !(Ld_id pending and not cleared by same-cycle Ld_done).
REQ-021 Accepted Ld_issue sets pending[Ld_id] next cycle; accepted Ld_done of a pending id writes Ld_data and clears pending.
REQ-022 Ld_done and Ld_issue, same id, same cycle: data written, pending stays set (clear-then-set).
REQ-023 Wr and Ld_done, different ids, same cycle: both written (two write ports).
REQ-024 Wr and Ld_done, same id, same cycle: Ld_data written first, then Wr_data wins (Wr is younger); pending cleared.
REQ-025 Read bypass priority per port: Wr (accepted) > Ld_done (valid) > stored value; Rp_busy = pending & !Ld_done-match.
REQ-026 Id 0 with ZERO_REG=1: Rp_data 0, Rp_busy 0, writes dropped, Ld_issue accepted but no pending set, Ld_done ignored without Err.
REQ-027 Ld_done to non-pending id (nonzero): no write, Err=1 next cycle for exactly one cycle.
REQ-028 Pend_cnt registered, equals popcount of pending bits; increments/decrements in the same cycle net to zero.
REQ-029 Zero latency for read/bypass; one cycle for pending/Pend_cnt/Err updates.

Reset
REQ-030 Rst clears all registers to 0, all pending bits, Pend_cnt=0, Err=0; Rst overrides same-cycle writes.
REQ-031 Rst mid-load: load forgotten; later Ld_done for that id yields Err pulse.
REQ-032 During Rst, Wr_ready and Ld_ready read 0.

Structure
REQ-033 Package regfile_pkg holds default XLEN/NREGS/NRP constants and the id-width function.
REQ-034 Sub-module rf_scoreboard holds pending bits, ready logic, Pend_cnt and Err; regfile_sb holds data array and bypass muxes.

Verification
REQ-035 After reset, Rp_id={5,0} -> Rp_data={0,0}, Rp_busy=0, Pend_cnt=0.
REQ-036 Ld_issue id 7; next cycle Rp_id 7 -> Rp_busy=1, Pend_cnt=1; Wr_en id 7 -> Wr_ready=0, no write; Ld_done id 7 data 0xDEADBEEF -> same-cycle Rp_data=0xDEADBEEF, Rp_busy=0, next Pend_cnt=0.
REQ-037 Ld_done id 3 (not pending) -> Err pulse one cycle, reg 3 unchanged.
REQ-038 Same cycle Ld_done id 4 = 0x11, Wr id 9 = 0x22, Ld_issue id 4 -> reg4=0x11, reg9=0x22, pending[4]=1, Pend_cnt unchanged.
REQ-039 Wr id 0 = 0xFFFF_FFFF, Ld_issue id 0 -> reg0 reads 0, Pend_cnt 0, no Err.
REQ-040 Ld_issue id 2, then Rst, then Ld_done id 2 -> Err pulse, reg2=0, Pend_cnt 0.
